// File: rtl/tpu_host_sequencer_if.sv
// rtl/tpu_host_sequencer_if.sv - host-side command, operand and result ports of the TPU sequencer
interface tpu_host_sequencer_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int DIM_W  = 8
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [DIM_W-1:0]          cmd_k;
  logic [DIM_W-1:0]          cmd_m;
  logic [DIM_W-1:0]          cmd_n;
  logic                      ld_valid;
  logic                      ld_ready;
  logic [LANES*DATA_W-1:0]   ld_data;
  logic                      res_valid;
  logic                      res_ready;
  logic [LANES*ACC_W-1:0]    res_data;
  logic                      res_last;
  logic                      done;
  logic                      err;

  modport master (
    output cmd_valid, cmd_k, cmd_m, cmd_n, ld_valid, ld_data, res_ready,
    input  cmd_ready, ld_ready, res_valid, res_data, res_last, done, err
  );

  modport slave (
    input  cmd_valid, cmd_k, cmd_m, cmd_n, ld_valid, ld_data, res_ready,
    output cmd_ready, ld_ready, res_valid, res_data, res_last, done, err
  );
endinterface

// File: rtl/tpu_host_sequencer.sv
// rtl/tpu_host_sequencer.sv - GEMM host sequencer: load A/B buffers, start TPU, wait, drain C
module tpu_host_sequencer #(
  parameter int LANES   = 4,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32,
  parameter int IDX_W   = 16,
  parameter int DIM_W   = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  tpu_host_sequencer_if.slave     host,
  output logic                    in_valid,
  output logic [DIM_W-1:0]        K,
  output logic [DIM_W-1:0]        M,
  output logic [DIM_W-1:0]        N,
  input  logic                    busy,
  output logic                    A_wr_en,
  output logic [IDX_W-1:0]        A_index,
  output logic [LANES*DATA_W-1:0] A_data_in,
  output logic                    B_wr_en,
  output logic [IDX_W-1:0]        B_index,
  output logic [LANES*DATA_W-1:0] B_data_in,
  output logic [IDX_W-1:0]        C_index,
  input  logic [LANES*ACC_W-1:0]  C_data_out
);
  localparam int RES_W = LANES*ACC_W;
  localparam int WC_W  = $clog2(TIMEOUT+1);
  localparam logic [WC_W-1:0] TMO_LAST = WC_W'(TIMEOUT-1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_START, S_WAIT, S_DRAIN
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  cnt;
  logic [WC_W-1:0]   wait_cnt;
  logic [DIM_W-1:0]  k_q, m_q, n_q;
  logic [IDX_W-1:0]  na_q, nb_q, nc_q;
  logic              c_vld, c_first;
  logic [RES_W-1:0]  c_hold;
  logic              done_q, err_q;

  logic [IDX_W-1:0]  m_blk, n_blk, na_new, nb_new, nc_new;
  logic              dim_zero, cmd_fire, ld_fire, ld_last, res_fire, c_last;
  logic              wait_go, wait_tmo;

  // Block counts round partial lanes up; all products wrap at IDX_W bits.
  always_comb begin
    m_blk  = (IDX_W'(host.cmd_m) + IDX_W'(LANES-1)) / IDX_W'(LANES);
    n_blk  = (IDX_W'(host.cmd_n) + IDX_W'(LANES-1)) / IDX_W'(LANES);
    na_new = m_blk * IDX_W'(host.cmd_k);
    nb_new = n_blk * IDX_W'(host.cmd_k);
    nc_new = IDX_W'(host.cmd_m) * n_blk;
  end

  assign dim_zero = (host.cmd_k == '0) || (host.cmd_m == '0) || (host.cmd_n == '0);
  assign cmd_fire = (state == S_IDLE) && host.cmd_valid;
  assign ld_fire  = ((state == S_LOAD_A) || (state == S_LOAD_B)) && host.ld_valid;
  assign ld_last  = (cnt == (((state == S_LOAD_A) ? na_q : nb_q) - IDX_W'(1)));
  assign c_last   = (cnt == nc_q - IDX_W'(1));
  assign res_fire = (state == S_DRAIN) && c_vld && host.res_ready;
  // busy is not trusted on the first WAIT cycle: the TPU has not yet seen in_valid.
  assign wait_go  = (wait_cnt != '0) && !busy;
  assign wait_tmo = !wait_go && (wait_cnt == TMO_LAST);

  always_comb begin
    state_nxt      = state;
    host.cmd_ready = 1'b0;
    host.ld_ready  = 1'b0;
    host.res_valid = 1'b0;
    host.res_data  = '0;
    host.res_last  = 1'b0;
    host.done      = 1'b0;
    host.err       = 1'b0;
    in_valid       = 1'b0;
    K              = '0;
    M              = '0;
    N              = '0;
    A_wr_en        = 1'b0;
    A_index        = '0;
    A_data_in      = '0;
    B_wr_en        = 1'b0;
    B_index        = '0;
    B_data_in      = '0;
    C_index        = '0;
    if (!rst) begin
      host.done = done_q;
      host.err  = err_q;
      if (state != S_IDLE) begin
        K = k_q;
        M = m_q;
        N = n_q;
      end
      case (state)
        S_IDLE: begin
          host.cmd_ready = 1'b1;
          if (host.cmd_valid && !dim_zero) state_nxt = S_LOAD_A;
        end
        S_LOAD_A: begin
          host.ld_ready = 1'b1;
          A_wr_en       = host.ld_valid;
          A_index       = cnt;
          A_data_in     = host.ld_data;
          if (host.ld_valid && ld_last) state_nxt = S_LOAD_B;
        end
        S_LOAD_B: begin
          host.ld_ready = 1'b1;
          B_wr_en       = host.ld_valid;
          B_index       = cnt;
          B_data_in     = host.ld_data;
          if (host.ld_valid && ld_last) state_nxt = S_START;
        end
        S_START: begin
          in_valid  = 1'b1;
          state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (wait_go)       state_nxt = S_DRAIN;
          else if (wait_tmo) state_nxt = S_IDLE;
        end
        S_DRAIN: begin
          C_index        = cnt;
          host.res_valid = c_vld;
          // First valid cycle passes the fresh read through; later stall cycles replay the capture.
          host.res_data  = c_vld ? (c_first ? C_data_out : c_hold) : '0;
          host.res_last  = c_vld && c_last;
          if (res_fire && c_last) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      wait_cnt <= '0;
      k_q      <= '0;
      m_q      <= '0;
      n_q      <= '0;
      na_q     <= '0;
      nb_q     <= '0;
      nc_q     <= '0;
      c_vld    <= 1'b0;
      c_first  <= 1'b0;
      c_hold   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (cmd_fire) begin
        if (dim_zero) begin
          err_q <= 1'b1;
        end else begin
          k_q  <= host.cmd_k;
          m_q  <= host.cmd_m;
          n_q  <= host.cmd_n;
          na_q <= na_new;
          nb_q <= nb_new;
          nc_q <= nc_new;
          cnt  <= '0;
        end
      end
      if (ld_fire) cnt <= ld_last ? '0 : cnt + IDX_W'(1);
      if (state == S_START) wait_cnt <= '0;
      if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + WC_W'(1);
        if (wait_tmo) err_q <= 1'b1;
        if (wait_go) begin
          cnt   <= '0;
          c_vld <= 1'b0;
        end
      end
      if (state == S_DRAIN) begin
        if (!c_vld) begin
          c_vld   <= 1'b1;
          c_first <= 1'b1;
        end else begin
          c_first <= 1'b0;
          if (c_first) c_hold <= C_data_out;
          if (host.res_ready) begin
            c_vld <= 1'b0;
            if (c_last) begin
              done_q <= 1'b1;
              cnt    <= '0;
            end else begin
              cnt <= cnt + IDX_W'(1);
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_tpu_host_sequencer.sv
// tb/tb_tpu_host_sequencer.sv - directed self-checking bench for tpu_host_sequencer
module tb_tpu_host_sequencer;
  localparam int LANES = 4, DATA_W = 8, ACC_W = 32, IDX_W = 16, DIM_W = 8, TIMEOUT = 20;

  logic                    clk, rst, in_valid, busy, A_wr_en, B_wr_en;
  logic [DIM_W-1:0]        K, M, N;
  logic [IDX_W-1:0]        A_index, B_index, C_index;
  logic [LANES*DATA_W-1:0] A_data_in, B_data_in;
  logic [LANES*ACC_W-1:0]  c_rd;

  int nvec  = 0;
  int nfail = 0;

  tpu_host_sequencer_if #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .DIM_W(DIM_W)) hif();

  tpu_host_sequencer #(
    .LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .IDX_W(IDX_W), .DIM_W(DIM_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .host(hif),
    .in_valid(in_valid), .K(K), .M(M), .N(N), .busy(busy),
    .A_wr_en(A_wr_en), .A_index(A_index), .A_data_in(A_data_in),
    .B_wr_en(B_wr_en), .B_index(B_index), .B_data_in(B_data_in),
    .C_index(C_index), .C_data_out(c_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] c_word(input logic [IDX_W-1:0] i);
    return {32'hC300_0000 | 32'(i), 32'hC200_0000 | 32'(i), 32'hC100_0000 | 32'(i), 32'hC000_0000 | 32'(i)};
  endfunction

  // C buffer with one-cycle read latency
  always @(posedge clk) c_rd <= c_word(C_index);

  // Fake TPU: busy for 10 cycles after each start, or stuck high on demand
  int   busy_cnt   = 0;
  logic busy_stuck = 1'b0;
  always @(posedge clk) begin
    if (in_valid) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign busy = busy_stuck | (busy_cnt != 0);

  // Buffer-side monitor, sampled mid-cycle
  int a_cnt = 0, b_cnt = 0, iv_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic [31:0]      a_mem [0:63];
  logic [31:0]      b_mem [0:63];
  logic [IDX_W-1:0] a_last = '0, b_last = '0;
  always @(negedge clk) begin
    #2;
    if (A_wr_en) begin a_cnt++; a_last = A_index; a_mem[A_index[5:0]] = A_data_in; end
    if (B_wr_en) begin b_cnt++; b_last = B_index; b_mem[B_index[5:0]] = B_data_in; end
    if (in_valid)  iv_cnt++;
    if (hif.done)  done_cnt++;
    if (hif.err)   err_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input int k, input int m, input int n);
    int tmo = 0;
    @(negedge clk);
    hif.cmd_valid = 1'b1;
    hif.cmd_k = DIM_W'(k);
    hif.cmd_m = DIM_W'(m);
    hif.cmd_n = DIM_W'(n);
    #1;
    while (!hif.cmd_ready && tmo < 50) begin @(negedge clk); #1; tmo++; end
    chk("cmd_ready", hif.cmd_ready, 1);
    @(negedge clk);
    hif.cmd_valid = 1'b0;
  endtask

  task automatic load_stream(input int total, input int pct, input logic [31:0] base);
    int sent = 0, tmo = 0;
    logic acc;
    while (sent < total && tmo < 2000) begin
      @(negedge clk);
      hif.ld_valid = ($urandom_range(0, 99) < pct);
      hif.ld_data  = base + 32'(sent);
      #1;
      acc = hif.ld_valid && hif.ld_ready;
      @(posedge clk);
      if (acc) sent++;
      tmo++;
    end
    chk("ld_words", sent, total);
  endtask

  task automatic drain(input int nc, input int pct, input int stop);
    int got = 0, tmo = 0;
    logic prev_stall = 1'b0;
    logic [127:0] prev_data = '0;
    while (got < stop && tmo < 2000) begin
      @(negedge clk);
      hif.res_ready = ($urandom_range(0, 99) < pct);
      #1;
      if (prev_stall) begin
        chk("res_hold_valid", hif.res_valid, 1);
        chk("res_hold_data", hif.res_data, prev_data);
      end
      prev_stall = hif.res_valid && !hif.res_ready;
      prev_data  = hif.res_data;
      if (hif.res_valid && hif.res_ready) begin
        chk("res_data", hif.res_data, c_word(IDX_W'(got)));
        chk("res_last", hif.res_last, (got == nc - 1));
        chk("c_index", C_index, got);
        got++;
      end
      tmo++;
    end
    chk("res_words", got, stop);
    if (stop == nc) begin
      @(negedge clk);
      hif.res_ready = 1'b0;
      #1;
      chk("done_pulse", hif.done, 1);
      @(negedge clk);
      #1;
      chk("done_clear", hif.done, 0);
      chk("idle_after_done", hif.cmd_ready, 1);
    end
  endtask

  task automatic run_gemm(input int k, input int m, input int n, input int na, input int nb,
                          input int nc, input int ld_pct, input int rdy_pct, input logic [31:0] tag);
    int a0 = a_cnt, b0 = b_cnt, iv0 = iv_cnt, d0 = done_cnt;
    send_cmd(k, m, n);
    load_stream(na, ld_pct, 32'hA000_0000 | tag);
    load_stream(nb, ld_pct, 32'hB000_0000 | tag);
    @(negedge clk);
    hif.ld_valid = 1'b0;
    #1;
    chk("dim_k", K, k);
    chk("dim_m", M, m);
    chk("dim_n", N, n);
    chk("a_count", a_cnt - a0, na);
    chk("b_count", b_cnt - b0, nb);
    chk("a_last_idx", a_last, na - 1);
    chk("b_last_idx", b_last, nb - 1);
    for (int i = 0; i < na; i++) chk("a_data", a_mem[i], (32'hA000_0000 | tag) + 32'(i));
    for (int i = 0; i < nb; i++) chk("b_data", b_mem[i], (32'hB000_0000 | tag) + 32'(i));
    drain(nc, rdy_pct, nc);
    chk("start_pulses", iv_cnt - iv0, 1);
    chk("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    int cyc, e0, d0, a0;
    rst = 1'b1;
    hif.cmd_valid = 1'b0; hif.cmd_k = '0; hif.cmd_m = '0; hif.cmd_n = '0;
    hif.ld_valid = 1'b0; hif.ld_data = '0; hif.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", hif.cmd_ready, 0);
    chk("rst_ld_ready", hif.ld_ready, 0);
    chk("rst_res_valid", hif.res_valid, 0);
    chk("rst_in_valid", in_valid, 0);
    chk("rst_k", K, 0);
    chk("rst_a_index", A_index, 0);
    chk("rst_done_err", {hif.done, hif.err}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_cmd_ready", hif.cmd_ready, 1);

    // 1: 4x4x4, no gaps
    run_gemm(4, 4, 4, 4, 4, 4, 100, 100, 32'h0100);
    // 2: ragged lanes, NA=4 NB=4 NC=10
    run_gemm(2, 5, 6, 4, 4, 10, 100, 100, 32'h0200);
    // 3: random gaps, NA=6 NB=9 NC=21
    run_gemm(3, 7, 9, 6, 9, 21, 50, 30, 32'h0300);

    // 4: zero dimension
    a0 = a_cnt; e0 = err_cnt;
    send_cmd(4, 0, 4);
    #1;
    chk("zero_err_pulse", hif.err, 1);
    chk("zero_cmd_ready", hif.cmd_ready, 1);
    @(negedge clk);
    #1;
    chk("zero_err_clear", hif.err, 0);
    chk("zero_ld_ready", hif.ld_ready, 0);
    chk("zero_no_writes", a_cnt - a0, 0);
    chk("zero_err_count", err_cnt - e0, 1);

    // 5: timeout with busy stuck high
    busy_stuck = 1'b1;
    d0 = done_cnt;
    send_cmd(4, 4, 4);
    load_stream(4, 100, 32'hA000_0500);
    load_stream(4, 100, 32'hB000_0500);
    @(negedge clk);
    hif.ld_valid = 1'b0;
    #1;
    chk("tmo_start", in_valid, 1);
    cyc = 0;
    while (!hif.err && cyc < 100) begin @(negedge clk); #1; cyc++; end
    chk("tmo_latency", cyc, TIMEOUT + 1);
    chk("tmo_idle", hif.cmd_ready, 1);
    chk("tmo_no_done", done_cnt - d0, 0);
    busy_stuck = 1'b0;
    run_gemm(1, 1, 1, 1, 1, 1, 100, 100, 32'h0600);

    // 6a: reset mid-LOAD_B
    send_cmd(4, 4, 4);
    load_stream(4, 100, 32'hA000_0700);
    load_stream(2, 100, 32'hB000_0700);
    @(negedge clk);
    rst = 1'b1;
    hif.ld_valid = 1'b1;
    #1;
    chk("rstb_ld_ready", hif.ld_ready, 0);
    chk("rstb_b_wr_en", B_wr_en, 0);
    chk("rstb_cmd_ready", hif.cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstb_idle", hif.cmd_ready, 1);
    chk("rstb_b_wr_en_after", B_wr_en, 0);
    chk("rstb_k_zero", K, 0);
    hif.ld_valid = 1'b0;

    // 6b: reset mid-DRAIN
    d0 = done_cnt;
    send_cmd(4, 4, 4);
    load_stream(4, 100, 32'hA000_0800);
    load_stream(4, 100, 32'hB000_0800);
    @(negedge clk);
    hif.ld_valid = 1'b0;
    drain(4, 100, 2);
    @(negedge clk);
    rst = 1'b1;
    hif.res_ready = 1'b0;
    #1;
    chk("rstc_res_valid", hif.res_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rstc_no_done", done_cnt - d0, 0);
    chk("rstc_idle", hif.cmd_ready, 1);
    chk("rstc_res_valid_after", hif.res_valid, 0);
    run_gemm(2, 5, 6, 4, 4, 10, 60, 60, 32'h0900);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
